// File: rtl/wfa_pkg.sv
// Shared encodings for the WFA traceback path: TB pointer words, edit op codes,
// matrix identifiers and the walker FSM states.
package wfa_pkg;

    localparam logic [3:0] TB_MISMATCH = 4'b0000;
    localparam logic [3:0] TB_I_OPEN   = 4'b0101;
    localparam logic [3:0] TB_I_EXT    = 4'b0001;
    localparam logic [3:0] TB_D_OPEN   = 4'b1010;
    localparam logic [3:0] TB_D_EXT    = 4'b0010;
    localparam logic [3:0] TB_INVALID  = 4'b1111;

    typedef enum logic [1:0] {
        OP_X = 2'd0,
        OP_I = 2'd1,
        OP_D = 2'd2
    } op_code_t;

    typedef enum logic [1:0] {
        MAT_M = 2'd0,
        MAT_I = 2'd1,
        MAT_D = 2'd2
    } mat_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/wfa_tb_decode.sv
// Combinational TB pointer decoder: pointer + current matrix -> op, score step,
// diagonal step, next matrix, and whether this is an M->I/D hop or illegal.
module wfa_tb_decode
    import wfa_pkg::*;
(
    input  logic [3:0]        ptr_i,
    input  mat_t              mat_i,
    output op_code_t          op_o,
    output logic [1:0]        ds_o,
    output logic signed [1:0] dk_o,
    output mat_t              next_mat_o,
    output logic              switch_o,
    output logic              illegal_o
);

    always_comb begin
        op_o       = OP_X;
        ds_o       = 2'd1;
        dk_o       = 2'sd0;
        next_mat_o = MAT_M;
        switch_o   = 1'b0;
        illegal_o  = 1'b0;
        if (ptr_i == TB_INVALID) begin
            illegal_o = 1'b1;
        end else begin
            case (mat_i)
                MAT_M: begin
                    // An I/D source only changes matrix; the same pointer is reused.
                    case (ptr_i[1:0])
                        2'b00: next_mat_o = MAT_M;
                        2'b01: begin
                            switch_o   = 1'b1;
                            next_mat_o = MAT_I;
                        end
                        2'b10: begin
                            switch_o   = 1'b1;
                            next_mat_o = MAT_D;
                        end
                        default: illegal_o = 1'b1;
                    endcase
                end
                MAT_I: begin
                    op_o = OP_I;
                    dk_o = -2'sd1;
                    if (ptr_i[2]) begin
                        ds_o       = 2'd2;
                        next_mat_o = MAT_M;
                    end else begin
                        ds_o       = 2'd1;
                        next_mat_o = MAT_I;
                    end
                end
                MAT_D: begin
                    op_o = OP_D;
                    dk_o = 2'sd1;
                    if (ptr_i[3]) begin
                        ds_o       = 2'd2;
                        next_mat_o = MAT_M;
                    end else begin
                        ds_o       = 2'd1;
                        next_mat_o = MAT_D;
                    end
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/wfa_traceback_walker.sv
// Walks TB pointers back from (s,k) to (0,0) in M, emitting one X/I/D edit op
// per score step over a valid/ready port.
module wfa_traceback_walker
    import wfa_pkg::*;
#(
    parameter int LOG_MAX_WAVEFRONT_LEN = 8,
    parameter int DATA_WIDTH            = 8,
    parameter int TB_POINTER_WIDTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [LOG_MAX_WAVEFRONT_LEN-1:0]  start_s,
    input  logic signed [DATA_WIDTH-1:0]      start_k,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic                              tb_rd_en,
    output logic [LOG_MAX_WAVEFRONT_LEN-1:0]  tb_rd_s,
    output logic signed [DATA_WIDTH-1:0]      tb_rd_k,
    input  logic [TB_POINTER_WIDTH-1:0]       tb_rd_data,
    output logic                              op_valid,
    input  logic                              op_ready,
    output logic [1:0]                        op_code,
    output logic [LOG_MAX_WAVEFRONT_LEN-1:0]  op_s,
    output logic signed [DATA_WIDTH-1:0]      op_k,
    output state_t                            dbg_state
);

    localparam int LW = LOG_MAX_WAVEFRONT_LEN;
    localparam int DW = DATA_WIDTH;

    // Handshake: an op transfers on a rising edge where op_valid && op_ready;
    // while op_valid is high and op_ready low the op payload holds stable.

    state_t                  state_q, state_d;
    logic [LW-1:0]           s_q, s_d, nxt_s_q, nxt_s_d, op_s_q, op_s_d;
    logic signed [DW-1:0]    k_q, k_d, nxt_k_q, nxt_k_d, op_k_q, op_k_d;
    mat_t                    mat_q, mat_d, nxt_mat_q, nxt_mat_d;
    logic [TB_POINTER_WIDTH-1:0] ptr_q, ptr_d;
    op_code_t                op_code_q, op_code_d;

    op_code_t                dec_op;
    logic [1:0]              dec_ds;
    logic signed [1:0]       dec_dk;
    mat_t                    dec_next_mat;
    logic                    dec_switch, dec_illegal;

    logic signed [DW:0]      k_ext;
    logic                    k_ovf, s_short;

    wfa_tb_decode u_decode (
        .ptr_i      (ptr_q),
        .mat_i      (mat_q),
        .op_o       (dec_op),
        .ds_o       (dec_ds),
        .dk_o       (dec_dk),
        .next_mat_o (dec_next_mat),
        .switch_o   (dec_switch),
        .illegal_o  (dec_illegal)
    );

    // One extra bit catches k+-1 leaving the signed DW range.
    assign k_ext   = {k_q[DW-1], k_q} + {{(DW-1){dec_dk[1]}}, dec_dk};
    assign k_ovf   = (k_ext[DW] != k_ext[DW-1]);
    assign s_short = (s_q < LW'(dec_ds));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            k_q       <= '0;
            mat_q     <= MAT_M;
            ptr_q     <= '0;
            op_code_q <= OP_X;
            op_s_q    <= '0;
            op_k_q    <= '0;
            nxt_s_q   <= '0;
            nxt_k_q   <= '0;
            nxt_mat_q <= MAT_M;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            k_q       <= k_d;
            mat_q     <= mat_d;
            ptr_q     <= ptr_d;
            op_code_q <= op_code_d;
            op_s_q    <= op_s_d;
            op_k_q    <= op_k_d;
            nxt_s_q   <= nxt_s_d;
            nxt_k_q   <= nxt_k_d;
            nxt_mat_q <= nxt_mat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        k_d       = k_q;
        mat_d     = mat_q;
        ptr_d     = ptr_q;
        op_code_d = op_code_q;
        op_s_d    = op_s_q;
        op_k_d    = op_k_q;
        nxt_s_d   = nxt_s_q;
        nxt_k_d   = nxt_k_q;
        nxt_mat_d = nxt_mat_q;
        tb_rd_en  = 1'b0;
        op_valid  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d   = start_s;
                    k_d   = start_k;
                    mat_d = MAT_M;
                    state_d = (start_s == '0 && start_k == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                busy     = 1'b1;
                tb_rd_en = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                busy    = 1'b1;
                ptr_d   = tb_rd_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                busy = 1'b1;
                if (dec_illegal) begin
                    state_d = ST_ERR;
                end else if (dec_switch) begin
                    mat_d = dec_next_mat;
                end else if (s_short || k_ovf) begin
                    state_d = ST_ERR;
                end else begin
                    op_code_d = dec_op;
                    op_s_d    = s_q;
                    op_k_d    = k_q;
                    nxt_s_d   = s_q - LW'(dec_ds);
                    nxt_k_d   = k_ext[DW-1:0];
                    nxt_mat_d = dec_next_mat;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                if (op_ready) begin
                    s_d   = nxt_s_q;
                    k_d   = nxt_k_q;
                    mat_d = nxt_mat_q;
                    if (nxt_s_q == '0 && nxt_k_q != '0) begin
                        state_d = ST_ERR;
                    end else if (nxt_s_q == '0 && nxt_mat_q == MAT_M) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                error   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tb_rd_s   = s_q;
    assign tb_rd_k   = k_q;
    assign op_code   = op_code_q;
    assign op_s      = op_s_q;
    assign op_k      = op_k_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wfa_traceback_walker.sv
// Directed bench for wfa_traceback_walker: a TB memory model, an op scoreboard
// fed with expected ops before each walk, and per-walk completion checks.
module tb_wfa_traceback_walker;
    import wfa_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        start_s;
    logic signed [7:0] start_k;
    logic              busy, done, error;
    logic              tb_rd_en;
    logic [7:0]        tb_rd_s;
    logic signed [7:0] tb_rd_k;
    logic [3:0]        tb_rd_data;
    logic              op_valid, op_ready;
    logic [1:0]        op_code;
    logic [7:0]        op_s;
    logic signed [7:0] op_k;
    state_t            dbg_state;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int op_cnt = 0;

    logic [17:0] exp_q[$];

    logic [7:0]        mem_s[16];
    logic signed [7:0] mem_k[16];
    logic [3:0]        mem_p[16];
    int                mem_n = 0;

    wfa_traceback_walker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_s    (start_s),
        .start_k    (start_k),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .tb_rd_en   (tb_rd_en),
        .tb_rd_s    (tb_rd_s),
        .tb_rd_k    (tb_rd_k),
        .tb_rd_data (tb_rd_data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_s       (op_s),
        .op_k       (op_k),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- TB pointer memory model ----------------
    function automatic logic [3:0] lookup(input logic [7:0] s, input logic signed [7:0] k);
        for (int i = 0; i < mem_n; i++)
            if (mem_s[i] == s && mem_k[i] == k) return mem_p[i];
        return TB_INVALID;
    endfunction

    always @(posedge clk) begin
        if (tb_rd_en) tb_rd_data <= lookup(tb_rd_s, tb_rd_k);
        else          tb_rd_data <= TB_INVALID;
    end

    function automatic logic [17:0] pack_op(input logic [1:0] c, input logic [7:0] s,
                                            input logic signed [7:0] k);
        return {c, s, k};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [17:0] exp_op;
        if (tb_rd_en) rd_cnt++;
        if (op_valid && op_ready) begin
            op_cnt++;
            exp_op = (exp_q.size() != 0) ? exp_q.pop_front() : 18'bx;
            checks++;
            assert ({op_code, op_s, op_k} === exp_op) else begin
                errors++;
                $error("FAIL op observed=%h expected=%h", {op_code, op_s, op_k}, exp_op);
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        mem_n = 0;
    endtask

    task automatic add_mem(input logic [7:0] s, input logic signed [7:0] k, input logic [3:0] p);
        mem_s[mem_n] = s;
        mem_k[mem_n] = k;
        mem_p[mem_n] = p;
        mem_n++;
    endtask

    task automatic do_start(input logic [7:0] s, input logic signed [7:0] k);
        @(posedge clk); #1;
        start   = 1'b1;
        start_s = s;
        start_k = k;
        @(posedge clk); #1;
        start   = 1'b0;
        start_s = $urandom_range(0, 255);
        start_k = $urandom_range(0, 255);
    endtask

    task automatic wait_end(output logic got_done, output logic got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done)  begin got_done = 1'b1; break; end
            if (error) begin got_err  = 1'b1; break; end
        end
    endtask

    task automatic walk(input string tag, input logic [7:0] s, input logic signed [7:0] k,
                        input logic exp_done, input int exp_reads, input int exp_ops);
        int   r0, o0;
        logic gd, ge;
        r0 = rd_cnt;
        o0 = op_cnt;
        do_start(s, k);
        wait_end(gd, ge);
        check({tag, "_done"},  32'(gd), 32'(exp_done));
        check({tag, "_error"}, 32'(ge), 32'(!exp_done));
        check({tag, "_reads"}, rd_cnt - r0, exp_reads);
        check({tag, "_ops"},   op_cnt - o0, exp_ops);
        check({tag, "_q_empty"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          r0, o0, n;
        logic        gd, ge, seen;
        logic [17:0] held;

        rst      = 1'b1;
        start    = 1'b0;
        start_s  = '0;
        start_k  = '0;
        op_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy), 0);
        check("rst_done",     32'(done), 0);
        check("rst_error",    32'(error), 0);
        check("rst_rd_en",    32'(tb_rd_en), 0);
        check("rst_op_valid", 32'(op_valid), 0);
        check("rst_op_fields", 32'({op_code, op_s, op_k}), 0);
        check("rst_state",    32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // start at origin: done next cycle, no read, no op
        r0 = rd_cnt;
        o0 = op_cnt;
        do_start(8'd0, 8'sd0);
        check("zero_done_pulse", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("zero_done_one_cycle", 32'(done), 0);
        check("zero_reads", rd_cnt - r0, 0);
        check("zero_ops", op_cnt - o0, 0);

        // two mismatches
        clear_mem();
        add_mem(8'd2, 8'sd0, TB_MISMATCH);
        add_mem(8'd1, 8'sd0, TB_MISMATCH);
        exp_q.push_back(pack_op(OP_X, 8'd2, 8'sd0));
        exp_q.push_back(pack_op(OP_X, 8'd1, 8'sd0));
        walk("xx", 8'd2, 8'sd0, 1'b1, 2, 2);

        // M->I hop reuses the pointer, then an open lands on origin
        clear_mem();
        add_mem(8'd2, 8'sd1, TB_I_OPEN);
        exp_q.push_back(pack_op(OP_I, 8'd2, 8'sd1));
        walk("iopen", 8'd2, 8'sd1, 1'b1, 1, 1);

        // D extend then D open
        clear_mem();
        add_mem(8'd3, -8'sd2, TB_D_EXT);
        add_mem(8'd2, -8'sd1, TB_D_OPEN);
        exp_q.push_back(pack_op(OP_D, 8'd3, -8'sd2));
        exp_q.push_back(pack_op(OP_D, 8'd2, -8'sd1));
        walk("dd", 8'd3, -8'sd2, 1'b1, 2, 2);

        // invalid pointer
        clear_mem();
        add_mem(8'd1, 8'sd0, TB_INVALID);
        walk("invalid", 8'd1, 8'sd0, 1'b0, 1, 0);

        // M source 11 with a non-1111 word is also illegal
        clear_mem();
        add_mem(8'd4, 8'sd0, 4'b0011);
        walk("src11", 8'd4, 8'sd0, 1'b0, 1, 0);

        // open step needs s>=2
        clear_mem();
        add_mem(8'd1, 8'sd1, TB_I_OPEN);
        walk("open_s1", 8'd1, 8'sd1, 1'b0, 1, 0);

        // k+1 overflow on D extend
        clear_mem();
        add_mem(8'd1, 8'sd127, TB_D_EXT);
        walk("k_ovf", 8'd1, 8'sd127, 1'b0, 1, 0);

        // k-1 underflow on I extend
        clear_mem();
        add_mem(8'd1, -8'sd128, TB_I_EXT);
        walk("k_unf", 8'd1, -8'sd128, 1'b0, 1, 0);

        // mismatch reaching s==0 off the origin diagonal: op emitted, then error
        clear_mem();
        add_mem(8'd1, 8'sd1, TB_MISMATCH);
        exp_q.push_back(pack_op(OP_X, 8'd1, 8'sd1));
        walk("s0_k1", 8'd1, 8'sd1, 1'b0, 1, 1);

        // random-length mismatch chain on k=0
        n = $urandom_range(2, 6);
        clear_mem();
        for (int i = 1; i <= n; i++) add_mem(8'(i), 8'sd0, TB_MISMATCH);
        for (int i = n; i >= 1; i--) exp_q.push_back(pack_op(OP_X, 8'(i), 8'sd0));
        walk("xchain", 8'(n), 8'sd0, 1'b1, n, n);

        // backpressure on the first EMIT
        clear_mem();
        add_mem(8'd2, 8'sd0, TB_MISMATCH);
        add_mem(8'd1, 8'sd0, TB_MISMATCH);
        exp_q.push_back(pack_op(OP_X, 8'd2, 8'sd0));
        exp_q.push_back(pack_op(OP_X, 8'd1, 8'sd0));
        op_ready = 1'b0;
        r0 = rd_cnt;
        do_start(8'd2, 8'sd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_valid) begin seen = 1'b1; break; end
        end
        check("bp_valid_seen", 32'(seen), 1);
        held = {op_code, op_s, op_k};
        check("bp_first_payload", 32'(held), 32'(pack_op(OP_X, 8'd2, 8'sd0)));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", 32'(op_valid), 1);
            check("bp_payload_hold", 32'({op_code, op_s, op_k}), 32'(held));
            check("bp_no_read", 32'(tb_rd_en), 0);
        end
        check("bp_reads_during_stall", rd_cnt - r0, 1);
        @(posedge clk); #1;
        op_ready = 1'b1;
        wait_end(gd, ge);
        check("bp_done", 32'(gd), 1);
        check("bp_error", 32'(ge), 0);
        check("bp_reads", rd_cnt - r0, 2);
        check("bp_q_empty", exp_q.size(), 0);

        // reset mid-walk: silent abandon
        clear_mem();
        add_mem(8'd2, 8'sd0, TB_MISMATCH);
        add_mem(8'd1, 8'sd0, TB_MISMATCH);
        o0 = op_cnt;
        do_start(8'd2, 8'sd0);
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy",   32'(busy), 0);
        check("mid_rst_done",   32'(done), 0);
        check("mid_rst_error",  32'(error), 0);
        check("mid_rst_rd_en",  32'(tb_rd_en), 0);
        check("mid_rst_valid",  32'(op_valid), 0);
        check("mid_rst_fields", 32'({op_code, op_s, op_k}), 0);
        check("mid_rst_rd_addr", 32'({tb_rd_s, tb_rd_k}), 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || error) seen = 1'b1;
        end
        check("mid_rst_silent", 32'(seen), 0);
        check("mid_rst_no_ops", op_cnt - o0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
